// File: rtl/trisc_acc_pkg.sv
// Shared definitions for the TRISC accumulator control path.
//   op_e      : accumulator instruction opcodes (OP_ILL is the only illegal one)
//   seq_st_e  : acc_seq FSM states
//   CNT_W_DEF : default width of the repeat-count field
package trisc_acc_pkg;

  localparam int CNT_W_DEF = 4;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_CLR  = 3'd1,
    OP_LDA  = 3'd2,
    OP_LDB  = 3'd3,
    OP_INCN = 3'd4,
    OP_LDAI = 3'd5,
    OP_CLRI = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    REP   = 2'd2,
    FIN   = 2'd3
  } seq_st_e;

  // Opcodes that begin with a single clear/load cycle.
  function automatic logic has_first(op_e op);
    return (op == OP_CLR) || (op == OP_LDA) || (op == OP_LDB) ||
           (op == OP_LDAI) || (op == OP_CLRI);
  endfunction

endpackage

// File: rtl/acc_seq_rep_cnt.sv
// rep_cnt: loadable down-counter for the sequencer's inc repeat phase.
//   clk, rst_n : clock, synchronous active-low reset
//   load, d    : load d (takes priority over dec)
//   dec        : decrement by one
//   last       : counter currently holds 1
module rep_cnt #(
  parameter int CNT_W = trisc_acc_pkg::CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] d,
  output logic             last
);

  logic [CNT_W-1:0] q;

  always_ff @(posedge clk) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= d;
    else if (dec)  q <= q - 1'b1;
  end

  assign last = (q == CNT_W'(1));

endmodule

// File: rtl/acc_seq.sv
// acc_seq: expands one accumulator instruction at a time into clear/load/inc/AB
// strobes, then pulses done (and err for the illegal opcode).
//   clk, rst_n               : clock, synchronous active-low reset
//   instr_valid/instr_ready  : instruction handshake; opcode/count sampled on accept
//   clear, load, inc, AB     : accumulator control strobes (registered)
//   busy, done, err          : status (registered)
module acc_seq
  import trisc_acc_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       opcode,
  input  logic [CNT_W-1:0] count,
  output logic             clear,
  output logic             load,
  output logic             inc,
  output logic             AB,
  output logic             busy,
  output logic             done,
  output logic             err
);

  seq_st_e st, nxt;
  op_e     op_in;
  logic    rep_q;     // FIRST is followed by a repeat phase
  logic    cnt_ld, cnt_dec, cnt_last;
  logic    acc;

  assign op_in = op_e'(opcode);
  assign acc   = (st == IDLE) && instr_valid;

  rep_cnt #(.CNT_W(CNT_W)) u_rep_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .load (cnt_ld),
    .dec  (cnt_dec),
    .d    (count),
    .last (cnt_last)
  );

  always_comb begin
    nxt     = st;
    cnt_ld  = 1'b0;
    cnt_dec = 1'b0;
    case (st)
      IDLE: if (instr_valid) begin
        cnt_ld = 1'b1;
        if (has_first(op_in))                        nxt = FIRST;
        else if (op_in == OP_INCN && count != '0)    nxt = REP;
        else                                         nxt = FIN;
      end
      FIRST: nxt = rep_q ? REP : FIN;
      REP: begin
        if (cnt_last) nxt = FIN;
        else          cnt_dec = 1'b1;
      end
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so each strobe lines up with
  // the state it belongs to. FIRST and the illegal-opcode FIN are only ever
  // entered straight from IDLE, so the live opcode is the accepted one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st    <= IDLE;
      rep_q <= 1'b0;
      clear <= 1'b0;
      load  <= 1'b0;
      inc   <= 1'b0;
      AB    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      st    <= nxt;
      if (acc)
        rep_q <= (op_in == OP_LDAI || op_in == OP_CLRI) && (count != '0);
      clear <= (nxt == FIRST) && (op_in == OP_CLR || op_in == OP_CLRI);
      load  <= (nxt == FIRST) && (op_in == OP_LDA || op_in == OP_LDB || op_in == OP_LDAI);
      AB    <= (nxt == FIRST) && (op_in == OP_LDB);
      inc   <= (nxt == REP);
      busy  <= (nxt != IDLE);
      done  <= (nxt == FIN);
      err   <= acc && (nxt == FIN) && (op_in == OP_ILL);
    end
  end

  assign instr_ready = ~busy;

endmodule

// File: tb/tb_acc_seq.sv
module tb_acc_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] opcode;
  logic [3:0] count;
  logic       clear, load, inc, AB, busy, done, err;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  // Expected per-cycle output vector {ready,busy,clear,load,inc,AB,done,err}.
  logic [7:0] q[$];
  localparam logic [7:0] IDLE_V = 8'b1000_0000;

  acc_seq #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .count(count), .clear(clear), .load(load), .inc(inc),
    .AB(AB), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic void push(bit c, bit l, bit i, bit a, bit d, bit e);
    q.push_back({1'b0, 1'b1, c, l, i, a, d, e});
  endfunction

  // Reference expansion straight from the instruction table.
  function automatic void expand(logic [2:0] op, logic [3:0] n);
    case (op)
      3'd1: push(1, 0, 0, 0, 0, 0);
      3'd2: push(0, 1, 0, 0, 0, 0);
      3'd3: push(0, 1, 0, 1, 0, 0);
      3'd4: for (int i = 0; i < n; i++) push(0, 0, 1, 0, 0, 0);
      3'd5: begin
        push(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) push(0, 0, 1, 0, 0, 0);
      end
      3'd6: begin
        push(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) push(0, 0, 1, 0, 0, 0);
      end
      default: ;
    endcase
    push(0, 0, 0, 0, 1, (op == 3'd7));
  endfunction

  // Check the current cycle, then drive inputs for the coming edge.
  task automatic step(input logic v, input logic [2:0] op, input logic [3:0] n,
                      input logic r, input string tag);
    logic [7:0] got, exp;
    bit was_idle;
    @(negedge clk);
    cyc++;
    got = {instr_ready, busy, clear, load, inc, AB, done, err};
    exp = (q.size() != 0) ? q[0] : IDLE_V;
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
    was_idle = (q.size() == 0);
    if (!was_idle) void'(q.pop_front());
    instr_valid = v;
    opcode      = op;
    count       = n;
    rst_n       = r;
    if (!r)                q.delete();
    else if (was_idle && v) expand(op, n);
  endtask

  // Issue one instruction, then idle with garbage on opcode/count until done.
  task automatic issue(input logic [2:0] op, input logic [3:0] n, input string tag);
    step(1'b1, op, n, 1'b1, tag);
    for (int i = 0; i < 40 && q.size() != 0; i++)
      step(1'b0, 3'($urandom), 4'($urandom), 1'b1, tag);
    step(1'b0, 3'($urandom), 4'($urandom), 1'b1, tag);
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; opcode = '0; count = '0;
    repeat (2) @(posedge clk);
    step(1'b0, 3'd0, 4'd0, 1'b1, "reset");

    issue(3'd3, 4'd9,  "ldb");
    issue(3'd5, 4'd3,  "ldai3");
    issue(3'd4, 4'd0,  "incn0");
    issue(3'd0, 4'd7,  "nop");
    issue(3'd4, 4'd15, "incn15");
    issue(3'd7, 4'd2,  "ill");
    issue(3'd6, 4'd0,  "clri0");
    issue(3'd2, 4'd4,  "lda");
    issue(3'd1, 4'd15, "clr");

    // Reset during the second cycle of CLRI N=5.
    step(1'b1, 3'd6, 4'd5, 1'b1, "clri_rst");
    step(1'b0, 3'd0, 4'd0, 1'b1, "clri_rst");
    step(1'b0, 3'd0, 4'd0, 1'b0, "clri_rst");
    step(1'b0, 3'd0, 4'd0, 1'b1, "after_rst");
    issue(3'd1, 4'd0, "clr_after_rst");

    // Valid held high with opcode/count changing every cycle.
    for (int i = 0; i < 300; i++)
      step(1'b1, 3'($urandom), 4'($urandom), 1'b1, "b2b");
    // Sparse valid.
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), 3'($urandom), 4'($urandom), 1'b1, "rand");
    for (int i = 0; i < 40 && q.size() != 0; i++)
      step(1'b0, 3'd0, 4'd0, 1'b1, "drain");
    step(1'b0, 3'd0, 4'd0, 1'b1, "final_idle");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
